mux8way16_arbiter: RTL and testbench
====================================

# mux8way16_arbiter

Round-robin arbiter that shares one 16-bit data path among eight requesters by sequencing the select of an 8-way 16-bit multiplexer. Each requester raises a request and holds its data word. The arbiter picks one requester fairly, steers that word onto a single output bus, and presents it with a valid/ready handshake. It acknowledges the winning requester when the consumer accepts the word. The block sits between the eight data sources and a single downstream consumer, such as a register or memory write port.

## Interface
- `WIDTH`, default 16: data word width per requester and output bus width.
- `clock` input 1: the only clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high. Sampled on the rising edge of `clock`.
- `req` input 8: `req[i]` = requester i has a word pending.
- `d0`..`d7` input WIDTH each: requester data words. `d[i]` must be stable while `req[i]` is high and not yet acked.
- `ready` input 1: the consumer can accept the word this cycle.
- `out` output WIDTH: the selected data word, equal to `d[sel]`. Combinational through the 8-way mux from registered `sel`.
- `valid` output 1: `out` holds a granted word.
- `sel` output 3: index of the current or most recent grant. Registered.
- `grant` output 8: one-hot grant. Registered; all zero when not in GRANT.
- `ack` output 8: one-hot transfer acknowledge, `ack[i] = grant[i] & ready`. Combinational.

## Operation
- **State machine:** two states, IDLE and GRANT. Priority pointer `ptr` is 3 bits.
- **IDLE:**
  - `valid` = 0, `grant` = 0, `ack` = 0.
  - If `req` != 0, search indices ptr, ptr+1, … ptr+7 modulo 8. The first index with `req[i]` = 1 wins.
  - On the edge: `sel` <= winner, `grant` <= one-hot(winner), state <= GRANT.
  - If `req` == 0, stay in IDLE; `sel` holds its value.
- **GRANT:**
  - `valid` = 1; `out` = `d[sel]`.
  - `req` is ignored. A requester may not withdraw; the grant holds until transfer.
  - If `ready` = 1, the transfer occurs this cycle:
    - `ack[sel]` = 1.
    - On the edge: `ptr` <= `sel`+1 (7 wraps to 0), `grant` <= 0, state <= IDLE.
  - If `ready` = 0, hold `sel`, `grant`, `valid` and `out` unchanged.
- **Fairness:** the most recent winner becomes lowest priority. With all eight requesting, every requester is served once in every eight transfers.
- **Requester obligation:** drop `req[i]` on the edge where `ack[i]` = 1, or the same requester re-enters arbitration at lowest priority.
- **Reset:**
  - State = IDLE, `ptr` = 0, `sel` = 0, `grant` = 0. Therefore `valid` = 0 and `ack` = 0.
  - `out` = `d0` after reset, since `sel` = 0. Consumers must qualify `out` with `valid`.
- **Reset mid-GRANT:** reset wins. No `ack` is registered as a transfer, `ptr` returns to 0, and the pending requester must be re-granted.

## Timing
- **Grant latency:** `req` sampled high in IDLE gives `valid`/`grant`/`sel` in the next cycle (1 clock).
- **Ack:** `ack` is valid in the same cycle as `valid & ready`. There is no registered delay.
- **Throughput:** at most one transfer every 2 cycles, because there is a mandatory IDLE bubble after each transfer.
- **Stability:** `sel`, `grant` and `valid` change only on rising edges. `out` changes only when `sel` changes or the selected `d[i]` changes.
- **Simultaneous requests:** resolved purely by `ptr` order. Ties cannot occur.
- **Wrap-around:** a grant to 7 sets `ptr` = 0, so requester 0 is first priority next.

## Test plan
Data words for all scenarios: d0=16'h1234, d1=16'h2345, d2=16'h3456, d3=16'h4567, d4=16'h5678, d5=16'h6789, d6=16'h789A, d7=16'h89AB.

1. **Reset:** hold `reset`=1 for 2 cycles with `req`=8'hFF -> `valid`=0, `grant`=0, `ack`=0, `sel`=0 after each edge.
2. **Single request:** `req`=8'b00001000, `ready`=1 -> one cycle later `valid`=1, `sel`=3, `grant`=8'b00001000, `out`=16'h4567, `ack`=8'b00001000. Next cycle `valid`=0.
3. **Round-robin order:** `req`=8'hFF held, `ready`=1 -> `sel` sequence 0,1,2,3,4,5,6,7,0, one grant every 2 cycles. `out` follows 16'h1234, 16'h2345, … 16'h89AB, 16'h1234.
4. **Backpressure:** `req`=8'b00100000, `ready`=0 for 4 cycles -> `valid`=1, `sel`=5, `out`=16'h6789 stable, `ack`=0 throughout. Raise `ready`=1 -> `ack`=8'b00100000 that cycle, IDLE next.
5. **Wrap:** after a grant to 7, present `req`=8'b01000001 -> grant to 0 (`out`=16'h1234), then to 6 (`out`=16'h789A).
6. **Reset mid-GRANT:** requester 4 granted with `ready`=0; assert `reset` for 1 cycle -> `valid`=0, `grant`=0, no `ack`. With `req[4]` still high, the re-grant occurs 1 cycle after `reset` drops.

Source files
------------

// File: rtl/mux8way16_arbiter.sv
// Round-robin arbiter steering one of eight requester words onto a single
// valid/ready output bus; the most recent winner drops to lowest priority.
module mux8way16_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic [WIDTH-1:0] d5,
  input  logic [WIDTH-1:0] d6,
  input  logic [WIDTH-1:0] d7,
  input  logic             ready,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic [2:0]       sel,
  output logic [7:0]       grant,
  output logic [7:0]       ack
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0] state_reg, state_next;
  logic [2:0] ptr_reg, ptr_next;
  logic [2:0] sel_reg, sel_next;
  logic [7:0] grant_reg, grant_next;

  logic [WIDTH-1:0] data [8];
  logic             found;
  logic [2:0]       winner;
  logic [2:0]       idx;

  assign data[0] = d0;
  assign data[1] = d1;
  assign data[2] = d2;
  assign data[3] = d3;
  assign data[4] = d4;
  assign data[5] = d5;
  assign data[6] = d6;
  assign data[7] = d7;

  // Scan from the farthest offset down so the nearest request to ptr wins.
  always_comb begin
    found  = 1'b0;
    winner = ptr_reg;
    idx    = ptr_reg;
    for (int k = 7; k >= 0; k--) begin
      idx = ptr_reg + 3'(k);
      if (req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    sel_next   = sel_reg;
    grant_next = grant_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          sel_next   = winner;
          grant_next = 8'b1 << winner;
          state_next = GRANT;
        end
      end
      default: begin
        if (ready) begin
          ptr_next   = sel_reg + 3'd1;
          grant_next = 8'b0;
          state_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      ptr_reg   <= 3'd0;
      sel_reg   <= 3'd0;
      grant_reg <= 8'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      sel_reg   <= sel_next;
      grant_reg <= grant_next;
    end
  end

  assign valid = (state_reg == GRANT);
  assign sel   = sel_reg;
  assign grant = grant_reg;
  assign ack   = grant_reg & {8{ready}};
  assign out   = data[sel_reg];

endmodule

// File: tb/tb_mux8way16_arbiter.sv
// Scoreboard bench: a cycle model predicts grants into a queue, and a monitor
// on the falling edge compares whatever the arbiter presents.
module tb_mux8way16_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  req;
  logic        ready;
  logic [15:0] d0, d1, d2, d3, d4, d5, d6, d7;
  logic [15:0] out;
  logic        valid;
  logic [2:0]  sel;
  logic [7:0]  grant;
  logic [7:0]  ack;

  mux8way16_arbiter #(.WIDTH(16)) dut (
    .clock(clock), .reset(reset), .req(req),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7),
    .ready(ready), .out(out), .valid(valid), .sel(sel), .grant(grant), .ack(ack)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          who;
    logic [15:0] word;
    logic [7:0]  onehot;
  } exp_t;

  logic [15:0] words [8];
  exp_t        exp_q [$];
  int          acc_q [$];
  int          n_checks = 0;
  int          n_fails  = 0;

  // Reference model state: an outstanding grant and the priority start point.
  bit m_busy = 1'b0;
  int m_ptr  = 0;
  int m_who  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_val);
    n_checks++;
    if (act !== req_val) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req_val, $time);
    end
  endtask

  always @(posedge clock) begin
    if (reset) begin
      m_busy = 1'b0;
      m_ptr  = 0;
      exp_q.delete();
    end else if (m_busy) begin
      if (ready) begin
        m_busy = 1'b0;
        m_ptr  = (m_who + 1) % 8;
      end
    end else if (req != 8'b0) begin
      for (int k = 0; k < 8; k++) begin
        if (req[(m_ptr + k) % 8]) begin
          m_who = (m_ptr + k) % 8;
          break;
        end
      end
      m_busy = 1'b1;
      exp_q.push_back('{who: m_who, word: words[m_who], onehot: 8'(1 << m_who)});
    end
  end

  always @(negedge clock) begin
    exp_t e;
    chk("valid", 32'(valid), 32'(m_busy));
    if (valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", 32'(valid), 32'd0);
      end else begin
        e = exp_q[0];
        chk("sel", 32'(sel), 32'(e.who));
        chk("out", 32'(out), 32'(e.word));
        chk("grant", 32'(grant), 32'(e.onehot));
        if (ready) begin
          chk("ack", 32'(ack), 32'(e.onehot));
          acc_q.push_back(e.who);
          void'(exp_q.pop_front());
        end else begin
          chk("ack_held", 32'(ack), 32'd0);
        end
      end
    end else begin
      chk("grant_idle", 32'(grant), 32'd0);
      chk("ack_idle", 32'(ack), 32'd0);
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic chk_order(input string name, input int want []);
    chk({name, "_count"}, 32'(acc_q.size()), 32'(want.size()));
    for (int i = 0; i < want.size() && i < acc_q.size(); i++)
      chk(name, 32'(acc_q[i]), 32'(want[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    d0 = 16'h1234; d1 = 16'h2345; d2 = 16'h3456; d3 = 16'h4567;
    d4 = 16'h5678; d5 = 16'h6789; d6 = 16'h789A; d7 = 16'h89AB;
    words = '{16'h1234, 16'h2345, 16'h3456, 16'h4567, 16'h5678, 16'h6789, 16'h789A, 16'h89AB};
    reset = 1'b1;
    req   = 8'hFF;
    ready = 1'b0;

    // Reset held with everyone requesting.
    for (int i = 0; i < 2; i++) begin
      step();
      #2;
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_out", 32'(out), 32'h1234);
    end

    // Single request, immediate accept.
    req = 8'b0000_1000; ready = 1'b1; reset = 1'b0;
    step();
    #2;
    chk("single_sel", 32'(sel), 32'd3);
    chk("single_out", 32'(out), 32'h4567);
    chk("single_ack", 32'(ack), 32'h08);
    req = 8'b0;
    step();
    #2;
    chk("single_bubble", 32'(valid), 32'd0);

    // Round-robin from a fresh pointer.
    reset = 1'b1;
    step();
    reset = 1'b0; req = 8'hFF; ready = 1'b1;
    acc_q.delete();
    step(18);
    req = 8'b0;
    step();
    chk_order("rr_order", '{0, 1, 2, 3, 4, 5, 6, 7, 0});

    // Backpressure: grant must hold steady.
    req = 8'b0010_0000; ready = 1'b0;
    step();
    req = 8'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("bp_out", 32'(out), 32'h6789);
      chk("bp_sel", 32'(sel), 32'd5);
      step();
    end
    ready = 1'b1;
    #2;
    chk("bp_ack", 32'(ack), 32'h20);
    step(2);

    // Wrap: winner 7 hands first priority to 0.
    acc_q.delete();
    req = 8'h80;
    step();
    req = 8'b0;
    step();
    req = 8'b0100_0001;
    step(2);
    req = 8'b0100_0000;
    step(2);
    req = 8'b0;
    step();
    chk_order("wrap_order", '{7, 0, 6});

    // Reset while a grant is pending: no transfer, re-grant afterwards.
    req = 8'b0001_0000; ready = 1'b0;
    step(2);
    chk("mid_valid", 32'(valid), 32'd1);
    chk("mid_sel", 32'(sel), 32'd4);
    reset = 1'b1;
    step();
    #2;
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_grant", 32'(grant), 32'd0);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    reset = 1'b0;
    step();
    chk("regrant_valid", 32'(valid), 32'd1);
    chk("regrant_grant", 32'(grant), 32'h10);
    ready = 1'b1; req = 8'b0;
    step(2);

    // Random traffic; the monitor checks every presented word.
    for (int i = 0; i < 400; i++) begin
      req   = 8'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req = 8'b0; ready = 1'b1;
    step(3);
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
